// File: rtl/data_mem_p.sv
// Single-port word memory with whole-array clear sequencer and range checking.
// Read latency 0 (READ_REG=0) or 1 cycle (READ_REG=1); AddrErr follows the access by one cycle.
// No backpressure: accesses during a clear are dropped, and Busy reports the clear.
module data_mem_p #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int DEPTH    = 256,
  parameter int READ_REG = 0
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] DataAddress,
  input  logic          ReadMem,
  input  logic          WriteMem,
  input  logic [DW-1:0] DataIn,
  input  logic          ClearReq,
  output logic [DW-1:0] DataOut,
  output logic          DataValid,
  output logic          Busy,
  output logic          AddrErr
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so DEPTH == 2^AW is representable in the range compare.
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] ptr;
  logic          busy_q;
  logic          addr_err_q;
  logic [DW-1:0] core [DEPTH];

  logic          in_range;
  logic          idle;
  logic          rd_ok;
  logic          wr_ok;
  logic          bad_acc;
  logic [DW-1:0] rd_dat;

  assign in_range = ({1'b0, DataAddress} < DEPTH_W);
  // Reset is treated like a clear in progress: nothing is accepted while it is held.
  assign idle     = (state == IDLE) && !reset;
  assign rd_ok    = idle && ReadMem && in_range;
  assign wr_ok    = idle && WriteMem && in_range;
  assign bad_acc  = idle && (ReadMem || WriteMem) && !in_range;
  // Read-first: this reads the array before the same-edge write lands.
  assign rd_dat   = rd_ok ? core[DataAddress] : '0;

  // Control FSM: clear sequencer, busy flag and the out-of-range pulse.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= CLEAR;
      ptr        <= '0;
      busy_q     <= 1'b1;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= bad_acc;
      case (state)
        CLEAR: begin
          if (ptr == LAST) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          // A write in the same cycle still lands; the clear then overwrites it.
          if (ClearReq) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Array write port: zeroing during a clear, user writes only when idle.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (state == CLEAR) begin
        core[ptr] <= '0;
      end else if (wr_ok) begin
        core[DataAddress] <= DataIn;
      end
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DW-1:0] dout_q;
      logic          valid_q;
      // Registered read data, aligned with its valid flag.
      always_ff @(posedge CLK) begin
        if (reset) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          dout_q  <= rd_dat;
          valid_q <= rd_ok;
        end
      end
      assign DataOut   = dout_q;
      assign DataValid = valid_q;
    end else begin : g_rd_comb
      assign DataOut   = rd_dat;
      assign DataValid = rd_ok;
    end
  endgenerate

  assign Busy    = busy_q;
  assign AddrErr = addr_err_q;

endmodule

// File: doc/data_mem_p.md
DATA_MEM_P -- requirements
Module: data_mem_p

Interface
REQ-001 SHALL provide parameter DW, default 8, meaning data word width in bits.
REQ-002 SHALL provide parameter AW, default 8, meaning address width in bits.
REQ-003 SHALL provide parameter DEPTH, default 256, meaning number of words, legal range 2..2^AW.
REQ-004 SHALL provide parameter READ_REG, default 0, meaning 0 = combinational read, 1 = registered read with one-cycle latency.
REQ-005 SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port DataAddress  input  AW  shared read/write word address.
REQ-008 SHALL have port ReadMem  input  1  read request.
REQ-009 SHALL have port WriteMem  input  1  write request.
REQ-010 SHALL have port DataIn  input  DW  write data.
REQ-011 SHALL have port ClearReq  input  1  request to zero the whole array.
REQ-012 SHALL have port DataOut  output  DW  read data.
REQ-013 SHALL have port DataValid  output  1  DataOut holds a valid read result.
REQ-014 SHALL have port Busy  output  1  clear sequence in progress.
REQ-015 SHALL have port AddrErr  output  1  one-cycle pulse for an out-of-range access.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (normal access) and CLEAR (zeroing).
REQ-017 CLEAR SHALL write 0 to word ptr each cycle, ptr counting 0..DEPTH-1, then go to IDLE on the cycle after writing DEPTH-1.
REQ-018 A full clear SHALL take exactly DEPTH cycles with Busy=1; Busy SHALL be 0 in IDLE.
REQ-019 ClearReq=1 in IDLE SHALL enter CLEAR with ptr=0 next cycle; ClearReq in CLEAR SHALL be ignored, with no restart.
REQ-020 In CLEAR, ReadMem and WriteMem SHALL be ignored: no write, DataValid=0, DataOut=0, AddrErr=0.
REQ-021 In IDLE, WriteMem=1 with DataAddress<DEPTH SHALL store DataIn at DataAddress on the clock edge.
REQ-022 In IDLE, ReadMem=1 with DataAddress<DEPTH SHALL return core[DataAddress]: same cycle if READ_REG=0, next cycle if READ_REG=1.
REQ-023 ReadMem and WriteMem to the same address in one cycle SHALL both be performed, read-first: the read returns the pre-write contents.
REQ-024 DataValid SHALL be 1 exactly when DataOut carries a read result, aligned to the READ_REG latency; otherwise DataOut SHALL be 0, never Z.
REQ-025 In IDLE, an access with DataAddress>=DEPTH SHALL suppress the write and return read data 0 with DataValid=0.
REQ-026 For such an out-of-range access, AddrErr SHALL pulse 1 for exactly one cycle on the cycle after the access.
REQ-027 ClearReq and WriteMem in the same IDLE cycle SHALL perform the write, then start CLEAR next cycle; the clear overwrites it.

Reset
REQ-028 reset=1 SHALL force state=CLEAR, ptr=0, DataOut=0, DataValid=0, AddrErr=0, Busy=1 on the next edge; no array write while reset is held.
REQ-029 After reset deasserts, SHALL perform a full DEPTH-cycle clear, so every word reads 0 after Busy falls.
REQ-030 reset asserted mid-CLEAR or mid-access SHALL abort the operation and restart the clear from ptr=0.

Verification
REQ-031 Reset, defaults: hold reset 2 cycles, release -> Busy=1 for exactly 256 cycles; then reading 0x00, 0x7F and 0xFF returns 0.
REQ-032 READ_REG=0: write 0xA5 @0x10, then read @0x10 -> DataOut=0xA5 and DataValid=1 in the same cycle; with ReadMem=0 -> DataOut=0.
REQ-033 READ_REG=1: read @0x10 holding 0xA5 -> DataOut=0xA5 and DataValid=1 one cycle later; simultaneous write 0x3C @0x10 with read -> returns 0xA5, then a re-read returns 0x3C.
REQ-034 DEPTH=200: write 0x55 @0xC8 -> AddrErr pulses 1 cycle, memory unchanged, DataValid=0; read @0xC7 -> DataValid=1.
REQ-035 ClearReq in IDLE -> Busy for DEPTH cycles; ClearReq and WriteMem pulsed during the clear -> ignored, and completion is still at DEPTH cycles.
REQ-036 reset pulsed at clear cycle 100 -> Busy stays 1 and the clear completes DEPTH cycles after reset is released.
